dmem_responder: RTL

Data-memory responder serving the CPU's load/store port over a request/response handshake with configurable access latency. It sits at the memory end of the MEM stage. It accepts one transaction at a time, stalls further requests while busy, performs word reads/writes on an internal array, and flags illegal accesses. A saturating error counter is provided for debug visibility.

---
 rtl/dmem_responder_if.sv | 44 ++++
 rtl/dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request/response bundle between the CPU MEM
// stage (master) and the data-memory responder (slave).
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   // CPU side: issues requests, consumes responses
   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_wdata,
      output req_be,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_err
   );

   // Memory side: accepts requests, produces responses
   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_wdata,
      input  req_be,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_err
   );

endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM stage.
// Accepts one load/store at a time, waits LATENCY cycles, then presents the
// response until the CPU takes it. Misaligned accesses and accesses to the
// 0x4xxxxxxx region are rejected and counted in a saturating 16-bit counter.
// Optional feature macro: DMEM_BYTE_EN -- when defined, stores honour the
// per-byte enables; otherwise every store writes the whole word.
module dmem_responder #(
   parameter int ADDR_WIDTH = 6,
   parameter int LATENCY    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   dmem_responder_if.slave        bus,
   output logic [15:0]            err_count
);

   localparam int         DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Control state
   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   resp_err_q, resp_err_d;
   logic [15:0]            err_cnt_q, err_cnt_d;

   // Latched request (data only, no reset needed)
   logic                   we_q;
   logic [ADDR_WIDTH-1:0]  idx_q;
   logic [31:0]            wdata_q;
   logic [3:0]             be_q;
   logic                   err_q;

   // Storage; intentionally not reset so contents survive reset
   logic [31:0]            mem [DEPTH];

   logic                   accept;
   logic                   enter_resp;
   logic                   req_err;
   logic [ADDR_WIDTH-1:0]  req_idx;

   // Transaction being committed on the edge entering RESP
   logic                   cur_we;
   logic                   cur_err;
   logic [ADDR_WIDTH-1:0]  cur_idx;
   logic [31:0]            cur_wdata;
   logic [3:0]             cur_be;
   logic [31:0]            merged;
   logic                   mem_wr;

   // Upper address bits only alias; they carry no meaning here
   logic                   unused_addr;
   assign unused_addr = ^bus.req_addr[27:ADDR_WIDTH+2];

   assign req_idx = bus.req_addr[ADDR_WIDTH+1:2];
   assign req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:28] == 4'h4);

   // State, latency counter, response and error-counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         rdata_q    <= 32'd0;
         resp_err_q <= 1'b0;
         err_cnt_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         resp_err_q <= resp_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               accept = 1'b1;
               if (LATENCY > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture the request on accept so the CPU may move on
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         idx_q   <= req_idx;
         wdata_q <= bus.req_wdata;
         be_q    <= bus.req_be;
         err_q   <= req_err;
      end
   end

   // With zero latency the commit happens on the accept edge, so use live inputs
   always_comb begin
      if (state_q == IDLE) begin
         cur_we    = bus.req_we;
         cur_idx   = req_idx;
         cur_wdata = bus.req_wdata;
         cur_be    = bus.req_be;
         cur_err   = req_err;
      end else begin
         cur_we    = we_q;
         cur_idx   = idx_q;
         cur_wdata = wdata_q;
         cur_be    = be_q;
         cur_err   = err_q;
      end
   end

`ifdef DMEM_BYTE_EN
   // Merge enabled bytes of the store into the current word
   always_comb begin
      merged = mem[cur_idx];
      for (int i = 0; i < 4; i++) begin
         if (cur_be[i]) begin
            merged[8*i +: 8] = cur_wdata[8*i +: 8];
         end
      end
   end
`else
   logic unused_be;
   assign unused_be = ^cur_be;

   // Full-word store; byte enables are ignored
   always_comb begin
      merged = cur_wdata;
   end
`endif

   // Gate with reset so a request seen while in reset can never write
   assign mem_wr = enter_resp && cur_we && !cur_err && reset;

   // Word array write port
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[cur_idx] <= merged;
      end
   end

   // Response data/error captured on RESP entry, held until the next one
   always_comb begin
      rdata_d    = rdata_q;
      resp_err_d = resp_err_q;
      if (enter_resp) begin
         resp_err_d = cur_err;
         if (cur_we || cur_err) begin
            rdata_d = 32'd0;
         end else begin
            rdata_d = mem[cur_idx];
         end
      end
   end

   // Rejected accesses counted on accept, saturating at all-ones
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && req_err && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign err_count      = err_cnt_q;

endmodule
